// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback source select and GPIO CSR addresses.
package cpu_pkg;

    typedef enum logic [1:0] {
        REGSEL_ALU  = 2'b00,
        REGSEL_GPIO = 2'b01,
        REGSEL_UIMM = 2'b10,
        REGSEL_RSVD = 2'b11
    } regsel_e;

    localparam logic [11:0] CSR_GPIO_IN  = 12'hF00;
    localparam logic [11:0] CSR_GPIO_OUT = 12'hF02;

endpackage

// File: rtl/wb_stage_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk. Backpressure: none, free-running.
// Reset clears both stages so nothing metastable leaks out of reset.
module sync2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: WB register, GPIO CSR in/out, operand forwarding, instret.
// Latency: 1 clk from EX capture to WB outputs; forwarding selects are combinational.
// Backpressure: stall/flush turn the captured slot into a bubble; nothing is held upstream.
module wb_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_EX,
    input  logic        regwrite_EX,
    input  logic [1:0]  regsel_EX,
    input  logic        GPIO_we,
    input  logic [11:0] csr_EX,
    input  logic [4:0]  rd_EX,
    input  logic [4:0]  rs1_EX,
    input  logic [4:0]  rs2_EX,
    input  logic [31:0] alu_result_EX,
    input  logic [19:0] imm20_EX,
    input  logic [31:0] rs1_data_EX,
    input  logic [31:0] gpio_in,
    input  logic        stall,
    input  logic        flush,
    output logic        regwrite_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] writedata_WB,
    output logic [31:0] gpio_out,
    output logic        fwd_rs1,
    output logic        fwd_rs2,
    output logic [31:0] instret
);

    logic        capture;
    logic [31:0] gpio_in_sync;
    logic [31:0] writedata_nxt;

    sync2 #(.W(32)) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (gpio_in_sync)
    );

    // flush and stall both force a bubble, so their relative priority is moot here
    assign capture = valid_EX && !stall && !flush;

    always_comb begin
        writedata_nxt = alu_result_EX;
        case (regsel_e'(regsel_EX))
            REGSEL_GPIO: writedata_nxt = gpio_in_sync;
            REGSEL_UIMM: writedata_nxt = {imm20_EX, 12'h000};
            default:     writedata_nxt = alu_result_EX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= '0;
            writedata_WB <= '0;
        end else if (capture) begin
            regwrite_WB  <= regwrite_EX && (rd_EX != 5'd0);
            rd_WB        <= rd_EX;
            writedata_WB <= writedata_nxt;
        end else begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= '0;
        end
    end

    // Read side samples the synchronizer, never gpio_out, so a csrrw swap returns the old input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
        end else if (capture && GPIO_we && (csr_EX == CSR_GPIO_OUT)) begin
            gpio_out <= rs1_data_EX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (capture) begin
            instret <= instret + 32'd1;
        end
    end

    assign fwd_rs1 = regwrite_WB && (rd_WB != 5'd0) && (rd_WB == rs1_EX);
    assign fwd_rs2 = regwrite_WB && (rd_WB != 5'd0) && (rd_WB == rs2_EX);

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_EX;
    logic        regwrite_EX;
    logic [1:0]  regsel_EX;
    logic        GPIO_we;
    logic [11:0] csr_EX;
    logic [4:0]  rd_EX;
    logic [4:0]  rs1_EX;
    logic [4:0]  rs2_EX;
    logic [31:0] alu_result_EX;
    logic [19:0] imm20_EX;
    logic [31:0] rs1_data_EX;
    logic [31:0] gpio_in;
    logic        stall;
    logic        flush;
    logic        regwrite_WB;
    logic [4:0]  rd_WB;
    logic [31:0] writedata_WB;
    logic [31:0] gpio_out;
    logic        fwd_rs1;
    logic        fwd_rs2;
    logic [31:0] instret;

    int checks_done;
    int checks_failed;

    wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_EX      (valid_EX),
        .regwrite_EX   (regwrite_EX),
        .regsel_EX     (regsel_EX),
        .GPIO_we       (GPIO_we),
        .csr_EX        (csr_EX),
        .rd_EX         (rd_EX),
        .rs1_EX        (rs1_EX),
        .rs2_EX        (rs2_EX),
        .alu_result_EX (alu_result_EX),
        .imm20_EX      (imm20_EX),
        .rs1_data_EX   (rs1_data_EX),
        .gpio_in       (gpio_in),
        .stall         (stall),
        .flush         (flush),
        .regwrite_WB   (regwrite_WB),
        .rd_WB         (rd_WB),
        .writedata_WB  (writedata_WB),
        .gpio_out      (gpio_out),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_done++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_EX      = 1'b0;
        regwrite_EX   = 1'b0;
        regsel_EX     = 2'b00;
        GPIO_we       = 1'b0;
        csr_EX        = 12'h000;
        rd_EX         = 5'd0;
        rs1_EX        = 5'd0;
        rs2_EX        = 5'd0;
        alu_result_EX = 32'h0;
        imm20_EX      = 20'h0;
        rs1_data_EX   = 32'h0;
        stall         = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [19:0] imm, input logic we, input logic [11:0] csr,
                         input logic [31:0] rs1d);
        valid_EX      = 1'b1;
        regwrite_EX   = 1'b1;
        regsel_EX     = sel;
        rd_EX         = rd;
        alu_result_EX = alu;
        imm20_EX      = imm;
        GPIO_we       = we;
        csr_EX        = csr;
        rs1_data_EX   = rs1d;
    endtask

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        idle_inputs();
        gpio_in = 32'h0;
        rst_n   = 1'b0;
        #12 rst_n = 1'b1;

        // ADD
        issue(2'b00, 5'd5, 32'h0000_1234, 20'h0, 1'b0, 12'h000, 32'h0);
        step();
        check("add_regwrite", {31'b0, regwrite_WB}, 32'd1);
        check("add_rd", {27'b0, rd_WB}, 32'd5);
        check("add_data", writedata_WB, 32'h0000_1234);
        check("add_instret", instret, 32'd1);

        // asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("rst_regwrite", {31'b0, regwrite_WB}, 32'd0);
        check("rst_rd", {27'b0, rd_WB}, 32'd0);
        check("rst_data", writedata_WB, 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_instret", instret, 32'd0);
        #1 rst_n = 1'b1;

        // first capture after reset release
        step();
        check("post_rst_regwrite", {31'b0, regwrite_WB}, 32'd1);
        check("post_rst_instret", instret, 32'd1);

        // LUI and forwarding
        issue(2'b10, 5'd3, 32'hFFFF_FFFF, 20'hABCDE, 1'b0, 12'h000, 32'h0);
        step();
        check("lui_data", writedata_WB, 32'hABCD_E000);
        check("lui_rd", {27'b0, rd_WB}, 32'd3);
        rs1_EX = 5'd3;
        rs2_EX = 5'd4;
        #1;
        check("lui_fwd_rs1", {31'b0, fwd_rs1}, 32'd1);
        check("lui_fwd_rs2", {31'b0, fwd_rs2}, 32'd0);
        rs2_EX = 5'd3;
        #1;
        check("lui_fwd_rs2_hit", {31'b0, fwd_rs2}, 32'd1);
        check("lui_instret", instret, 32'd2);

        // bubbles while gpio_in settles
        idle_inputs();
        gpio_in = 32'h55;
        for (int i = 0; i < 3; i++) step();
        check("bubble_regwrite", {31'b0, regwrite_WB}, 32'd0);
        check("bubble_instret", instret, 32'd2);

        // csrrw swap on GPIO_OUT
        issue(2'b01, 5'd7, 32'h0, 20'h0, 1'b1, 12'hF02, 32'h0000_DEAD);
        step();
        check("swap_gpio_out", gpio_out, 32'h0000_DEAD);
        check("swap_data", writedata_WB, 32'h55);
        check("swap_rd", {27'b0, rd_WB}, 32'd7);

        // same instruction aimed at GPIO_IN leaves gpio_out alone
        issue(2'b01, 5'd7, 32'h0, 20'h0, 1'b1, 12'hF00, 32'h0000_BEEF);
        step();
        check("csr_in_gpio_out", gpio_out, 32'h0000_DEAD);
        check("csr_in_data", writedata_WB, 32'h55);
        check("csr_in_instret", instret, 32'd4);

        // synchronizer latency: old value for two captures after a change
        issue(2'b01, 5'd8, 32'h0, 20'h0, 1'b0, 12'h000, 32'h0);
        gpio_in = 32'hAA;
        step();
        check("sync_lat1", writedata_WB, 32'h55);
        step();
        check("sync_lat2", writedata_WB, 32'h55);
        step();
        check("sync_lat3", writedata_WB, 32'hAA);

        // stall, then stall+flush
        issue(2'b00, 5'd9, 32'h1, 20'h0, 1'b1, 12'hF02, 32'h0000_1111);
        stall = 1'b1;
        step();
        check("stall_regwrite", {31'b0, regwrite_WB}, 32'd0);
        check("stall_rd", {27'b0, rd_WB}, 32'd0);
        check("stall_gpio_out", gpio_out, 32'h0000_DEAD);
        check("stall_instret", instret, 32'd7);
        flush = 1'b1;
        step();
        check("flush_regwrite", {31'b0, regwrite_WB}, 32'd0);
        check("flush_gpio_out", gpio_out, 32'h0000_DEAD);
        check("flush_instret", instret, 32'd7);

        // x0 write
        idle_inputs();
        issue(2'b00, 5'd0, 32'h77, 20'h0, 1'b0, 12'h000, 32'h0);
        step();
        check("x0_regwrite", {31'b0, regwrite_WB}, 32'd0);
        rs1_EX = 5'd0;
        #1;
        check("x0_fwd_rs1", {31'b0, fwd_rs1}, 32'd0);
        check("x0_instret", instret, 32'd8);

        // instret wrap
        @(negedge clk);
        force dut.instret = 32'hFFFF_FFFF;
        #1 release dut.instret;
        issue(2'b00, 5'd1, 32'h1, 20'h0, 1'b0, 12'h000, 32'h0);
        step();
        check("instret_wrap", instret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
